edge_spi_tx: RTL and testbench



---
 rtl/edge_pkg.sv | 24 ++
 rtl/edge_byte_fifo.sv | 58 +++++
 rtl/edge_spi_tx.sv | 144 ++++++++++++++
 tb/tb_edge_spi_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// edge_pkg: shared constants, FSM state type and byte-packing helper for the edge result SPI transmitter.
package edge_pkg;

    localparam int EDGE_W        = 2;
    localparam int VALS_PER_BYTE = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    // Status byte layout: {overflow, underflow, 2'b00, count[3:0]}
    localparam int STAT_OVF_BIT = 7;
    localparam int STAT_UNF_BIT = 6;
    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 4;

    // Slot 0 lands in bits [7:6], slot 3 in bits [1:0].
    function automatic logic [7:0] pack_slot(input logic [7:0] acc, input logic [1:0] slot,
                                             input logic [EDGE_W-1:0] v);
        pack_slot = acc | (8'(v) << (3'd6 - {slot, 1'b0}));
    endfunction

endpackage

// File: rtl/edge_byte_fifo.sv
// edge_byte_fifo: small byte FIFO between the edge packer and the SPI shifter.
//   clk, nreset       clock, asynchronous active-low reset
//   push, push_data   write strobe and byte; accepted when not full, or when full with a pop this cycle
//   pop, pop_data     read strobe; pop_data always shows the head entry
//   full, empty       status levels
//   count             current occupancy (DEPTH is at most 15)
module edge_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [3:0]    count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        full     = count_q == 4'(DEPTH);
        empty    = count_q == 4'd0;
        count    = count_q;
        pop_data = mem_q[rd_q];
        // When full, the slot being popped is the slot being written, so both can proceed.
        push_ok  = push & (~full | pop);
        pop_ok   = pop & ~empty;
        wr_d     = push_ok ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1)) : wr_q;
        rd_d     = pop_ok ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1)) : rd_q;
        count_d  = count_q + {3'b0, push_ok} - {3'b0, pop_ok};
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_q] = push_data;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/edge_spi_tx.sv
// edge_spi_tx: packs 2-bit edge results four per byte, queues them and shifts them out as an SPI mode-0 slave.
//   clk, nreset              system clock, asynchronous active-low reset
//   edgeVal, edgeValValid    edge code and its one-cycle qualifier
//   frameEnd                 one-cycle strobe flushing a partially packed byte
//   sck, cs_n                asynchronous SPI clock / chip select from the MCU
//   miso                     SPI data out (0 while deselected)
//   dataReady                FIFO non-empty
//   overflow                 sticky: a packed byte was dropped on a full FIFO
// Build option: EDGE_TX_STATUS_EN sends a status byte as the first byte of each transaction.
module edge_spi_tx
    import edge_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [EDGE_W-1:0] edgeVal,
    input  logic              edgeValValid,
    input  logic              frameEnd,
    input  logic              sck,
    input  logic              cs_n,
    output logic              miso,
    output logic              dataReady,
    output logic              overflow
);

    logic [2:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
    logic [7:0] acc_q, acc_d, shreg_q, shreg_d, packed_byte;
    logic [1:0] slot_q, slot_d;
    logic [2:0] fill, bit_cnt_q, bit_cnt_d;
    tx_state_t  state_q, state_d;
    logic       overflow_q, overflow_d;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       push, pop, load, first_load, data_load;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_data;
    logic [3:0] fifo_count;
`ifdef EDGE_TX_STATUS_EN
    logic       underflow_q, underflow_d, status_load;
    logic [7:0] status_byte;
`endif

    edge_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .push      (push),
        .push_data (packed_byte),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        // Two synchronizer stages then one edge-detect stage: events act on the third clk edge.
        sck_sync_d  = {sck_sync_q[1:0], sck};
        cs_sync_d   = {cs_sync_q[1:0], cs_n};
        sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
        sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
        cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
        cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
        // Packer: the incoming value is packed first, then a flush sees the updated fill level.
        packed_byte = edgeValValid ? pack_slot(acc_q, slot_q, edgeVal) : acc_q;
        fill        = {1'b0, slot_q} + {2'b0, edgeValValid};
        push        = (fill == 3'(VALS_PER_BYTE)) | (frameEnd & (fill != 3'd0));
        acc_d       = push ? 8'h00 : packed_byte;
        slot_d      = push ? 2'd0 : fill[1:0];
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        load        = 1'b0;
        first_load  = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d    = SHIFT;
                bit_cnt_d  = 3'd0;
                load       = 1'b1;
                first_load = 1'b1;
            end
        end else if (cs_rise) begin
            state_d = IDLE;
        end else if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
        end else if (sck_fall) begin
            if (bit_cnt_q != 3'd0) shreg_d = {shreg_q[6:0], 1'b0};
            else load = 1'b1;
        end
`ifdef EDGE_TX_STATUS_EN
        status_load = load & first_load;
        data_load   = load & ~first_load;
        status_byte = '0;
        status_byte[STAT_OVF_BIT] = overflow_q;
        status_byte[STAT_UNF_BIT] = underflow_q;
        status_byte[STAT_CNT_LSB +: STAT_CNT_W] = fifo_count;
        if (status_load) shreg_d = status_byte;
`else
        data_load   = load | (first_load & 1'b0);
`endif
        // Empty FIFO at Load time sends filler 0x00 without popping.
        pop = data_load & ~fifo_empty;
        if (data_load) shreg_d = fifo_empty ? 8'h00 : fifo_data;
`ifdef EDGE_TX_STATUS_EN
        // A drop in the same cycle as the status snapshot survives the clear.
        overflow_d  = (push & fifo_full & ~pop) | (overflow_q & ~status_load);
        underflow_d = (data_load & fifo_empty) | (underflow_q & ~status_load);
`else
        overflow_d  = (push & fifo_full & ~pop) | overflow_q;
`endif
        miso      = (state_q == SHIFT) & shreg_q[7];
        dataReady = fifo_count != 4'd0;
        overflow  = overflow_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sck_sync_q  <= 3'b000;
            // Resetting to 0 means cs_n held low across reset release produces no falling event.
            cs_sync_q   <= 3'b000;
            acc_q       <= '0;
            slot_q      <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            state_q     <= IDLE;
            overflow_q  <= 1'b0;
`ifdef EDGE_TX_STATUS_EN
            underflow_q <= 1'b0;
`endif
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            acc_q       <= acc_d;
            slot_q      <= slot_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
`ifdef EDGE_TX_STATUS_EN
            underflow_q <= underflow_d;
`endif
        end
    end

endmodule

// File: tb/tb_edge_spi_tx.sv
// tb_edge_spi_tx: randomized self-checking bench for edge_spi_tx against a queue-based reference model.
module tb_edge_spi_tx;

    localparam int DEPTH = 8;
`ifdef EDGE_TX_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic       clk = 1'b0, nreset = 1'b0;
    logic [1:0] edgeVal = 2'd0;
    logic       edgeValValid = 1'b0, frameEnd = 1'b0, sck = 1'b0, cs_n = 1'b1;
    logic       miso, dataReady, overflow;

    int         n_cmp = 0, n_err = 0;
    int         vals[$];
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0, m_unf = 1'b0;

    always #5 clk = ~clk;

    edge_spi_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .edgeVal      (edgeVal),
        .edgeValValid (edgeValValid),
        .frameEnd     (frameEnd),
        .sck          (sck),
        .cs_n         (cs_n),
        .miso         (miso),
        .dataReady    (dataReady),
        .overflow     (overflow)
    );

    function automatic void m_push_byte();
        logic [7:0] b = 8'h00;
        for (int i = 0; i < vals.size(); i++) b += 8'(vals[i] * (64 >> (2 * i)));
        vals.delete();
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    function automatic logic [7:0] m_load(input bit first);
        logic [7:0] b;
        if (STAT && first) begin
            b = {m_ovf, m_unf, 2'b00, 4'(mq.size())};
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (mq.size() > 0) begin
            b = mq.pop_front();
        end else begin
            b = 8'h00;
            if (STAT) m_unf = 1'b1;
        end
        return b;
    endfunction

    task automatic drive(input logic [1:0] v, input bit valid, input bit fe);
        edgeVal = v;
        edgeValValid = valid;
        frameEnd = fe;
        @(negedge clk);
        edgeValValid = 1'b0;
        frameEnd = 1'b0;
        if (valid) vals.push_back(int'(v));
        if (vals.size() == 4 || (fe && vals.size() > 0)) m_push_byte();
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] t = b << (2 * i);
            drive(t[7:6], 1'b1, 1'b0);
        end
    endtask

    task automatic check_flags(input string name);
        n_cmp += 2;
        if (dataReady !== (mq.size() != 0)) begin
            n_err++;
            $display("FAIL %s dataReady: got %b expected %b", name, dataReady, mq.size() != 0);
        end
        if (overflow !== m_ovf) begin
            n_err++;
            $display("FAIL %s overflow: got %b expected %b", name, overflow, m_ovf);
        end
    endtask

    // Reads nbits as an SPI mode-0 master; a Load happens at cs_n fall and after every full byte.
    task automatic spi_xfer(input int nbits, input string name);
        logic [7:0] exp[$];
        logic [7:0] gb = 8'h00, e;
        int r = nbits % 8;
        for (int k = 0; k <= nbits / 8; k++) exp.push_back(m_load(k == 0));
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            gb = {gb[6:0], miso};
            if (i % 8 == 7) begin
                n_cmp++;
                if (gb !== exp[i / 8]) begin
                    n_err++;
                    $display("FAIL %s byte%0d: got %02h expected %02h", name, i / 8, gb, exp[i / 8]);
                end
            end
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
            repeat (8) @(negedge clk);
        end
        if (r != 0) begin
            e = exp[nbits / 8] >> (8 - r);
            n_cmp++;
            if ((gb & 8'((1 << r) - 1)) !== e) begin
                n_err++;
                $display("FAIL %s partial: got %02h expected %02h", name, gb & 8'((1 << r) - 1), e);
            end
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (miso !== 1'b0 || dataReady !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset outputs: got miso=%b dr=%b ovf=%b expected 0 0 0", miso, dataReady, overflow);
        end
        nreset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        drive(2'd3, 1, 0);
        drive(2'd0, 1, 0);
        drive(2'd2, 1, 0);
        check_flags("basic_pre");
        drive(2'd1, 1, 0);
        check_flags("basic_push_latency");
        spi_xfer(8, "basic_c9");
        check_flags("basic_post");
    endtask

    task automatic test_frame_end();
        drive(2'd1, 1, 0);
        drive(2'd2, 1, 0);
        drive(2'd0, 0, 1);
        check_flags("fe_flush");
        drive(2'd0, 0, 1);
        check_flags("fe_noop");
        drive(2'd3, 1, 0);
        drive(2'd2, 1, 0);
        drive(2'd1, 1, 0);
        drive(2'd1, 1, 1);
        drive(2'd2, 1, 1);
        check_flags("fe_coincident");
        spi_xfer(32, "fe_read");
        check_flags("fe_post");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
        check_flags("ovf_set");
        spi_xfer(8 * DEPTH, "ovf_read");
        check_flags("ovf_post");
    endtask

    task automatic test_abort();
        push_byte(8'hA5);
        push_byte(8'($urandom));
        spi_xfer(3, "abort_a5");
        spi_xfer(8, "abort_next");
        check_flags("abort_post");
    endtask

    task automatic test_first_byte();
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
        spi_xfer(8, "first_a");
        spi_xfer(16, "first_b");
        check_flags("first_post");
    endtask

    task automatic test_reset_mid();
        push_byte(8'hFF);
        push_byte(8'hFF);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        sck = 1'b1;
        repeat (8) @(negedge clk);
        sck = 1'b0;
        repeat (4) @(negedge clk);
        nreset = 1'b0;
        #1;
        n_cmp += 3;
        if (miso !== 1'b0 || dataReady !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid outputs: got miso=%b dr=%b ovf=%b expected 0 0 0", miso, dataReady, overflow);
        end
        mq.delete();
        vals.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (miso !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid idle miso: got %b expected 0", miso);
        end
        push_byte(8'h3C);
        spi_xfer(16, "reset_mid_fresh");
        check_flags("reset_mid_post");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int nv = $urandom_range(0, 14);
            for (int j = 0; j < nv; j++) drive(2'($urandom), 1'b1, ($urandom_range(0, 5) == 0));
            drive(2'd0, 1'b0, $urandom_range(0, 1) == 1);
            check_flags("rand_push");
            spi_xfer(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8 * $urandom_range(1, 3), "rand_read");
            check_flags("rand_post");
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_frame_end();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_first_byte();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
